// File: rtl/regfile_decoded_if.sv
// Bus bundle for regfile_decoded: write request, two read ports and the decoded write enable.
// The master drives the requests; the slave (the register file) returns read data and the decode.
interface regfile_decoded_if #(
    parameter int ADDR_W = 2,
    parameter int WIDTH  = 8
);
    logic                   RegWrite;
    logic [ADDR_W-1:0]      WriteRegister;
    logic [WIDTH-1:0]       WriteData;
    logic [ADDR_W-1:0]      ReadRegister1;
    logic [ADDR_W-1:0]      ReadRegister2;
    logic [WIDTH-1:0]       ReadData1;
    logic [WIDTH-1:0]       ReadData2;
    logic [(2**ADDR_W)-1:0] wr_onehot;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2, wr_onehot
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2, wr_onehot
    );
endinterface

// File: rtl/regfile_decoded.sv
// 2**ADDR_W x WIDTH register file written through an enable-cascaded 1-to-2 decoder tree.
// Optional macro REGFILE_ZERO_REG_EN hardwires the top-index register to zero.
module regfile_decoded #(
    parameter int ADDR_W = 2,
    parameter int WIDTH  = 8,
    parameter int DELAY  = 50
) (
    input  logic             clk,
    input  logic             reset,
    regfile_decoded_if.slave bus
);
    localparam int NREG  = 2**ADDR_W;
    localparam int NODES = 2*NREG - 1;

    // DELAY only characterises settling time; it has no structural effect.
    if (DELAY < 0) begin : g_delay_chk
        $error("regfile_decoded: DELAY must be non-negative");
    end

    logic [NODES-1:0] tree;
    logic [NREG-1:0]  dec_en;
    logic [NREG-1:0]  wr_onehot_w;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    // Heap-ordered decoder tree: node p feeds 2p+1 (bit=0) and 2p+2 (bit=1), MSB at the root,
    // so leaf order matches the binary register index.
    assign tree[0] = bus.RegWrite;

    for (genvar l = 0; l < ADDR_W; l++) begin : g_level
        for (genvar n = 0; n < (2**l); n++) begin : g_node
            localparam int P = (2**l) - 1 + n;
            assign tree[2*P+1] = tree[P] & ~bus.WriteRegister[ADDR_W-1-l];
            assign tree[2*P+2] = tree[P] &  bus.WriteRegister[ADDR_W-1-l];
        end
    end

    assign dec_en = tree[NODES-1:NREG-1];

`ifdef REGFILE_ZERO_REG_EN
    assign wr_onehot_w = {1'b0, dec_en[NREG-2:0]};
`else
    assign wr_onehot_w = dec_en;
`endif

    assign bus.wr_onehot = wr_onehot_w;

    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            regs_d[k] = regs_q[k];
            if (wr_onehot_w[k]) begin
                regs_d[k] = bus.WriteData;
            end
        end
    end

    // Reset wins over any write presented at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    always_comb begin
        rd1 = regs_q[bus.ReadRegister1];
        rd2 = regs_q[bus.ReadRegister2];
`ifdef REGFILE_ZERO_REG_EN
        if (bus.ReadRegister1 == ADDR_W'(NREG-1)) rd1 = '0;
        if (bus.ReadRegister2 == ADDR_W'(NREG-1)) rd2 = '0;
`endif
    end

    assign bus.ReadData1 = rd1;
    assign bus.ReadData2 = rd2;
endmodule

// File: tb/tb_regfile_decoded.sv
// Directed bench for regfile_decoded: reset, writes, read-during-write, disabled writes,
// reset priority and the top-index register (with or without REGFILE_ZERO_REG_EN).
module tb_regfile_decoded;
    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    regfile_decoded_if #(.ADDR_W(2), .WIDTH(8)) bus ();

    regfile_decoded #(.ADDR_W(2), .WIDTH(8), .DELAY(50)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] idx;
        @(negedge clk);
        reset = 1'b1;
        edge_settle();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i);
            bus.ReadRegister1 = idx;
            bus.ReadRegister2 = idx;
            #1;
            compared++;
            if (bus.ReadData1 !== 8'h00) begin
                mismatched++;
                $display("FAIL reset_rd1[%0d]: got %h, expected 00", i, bus.ReadData1);
            end
            compared++;
            if (bus.ReadData2 !== 8'h00) begin
                mismatched++;
                $display("FAIL reset_rd2[%0d]: got %h, expected 00", i, bus.ReadData2);
            end
        end
        compared++;
        if (bus.wr_onehot !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_onehot: got %b, expected 0000", bus.wr_onehot);
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        bus.RegWrite = 1'b1; bus.WriteRegister = 2'd1; bus.WriteData = 8'hA5;
        #1;
        compared++;
        if (bus.wr_onehot !== 4'b0010) begin
            mismatched++;
            $display("FAIL write_onehot_r1: got %b, expected 0010", bus.wr_onehot);
        end
        edge_settle();
        @(negedge clk);
        bus.WriteRegister = 2'd2; bus.WriteData = 8'h3C;
        #1;
        compared++;
        if (bus.wr_onehot !== 4'b0100) begin
            mismatched++;
            $display("FAIL write_onehot_r2: got %b, expected 0100", bus.wr_onehot);
        end
        edge_settle();
        @(negedge clk);
        bus.RegWrite = 1'b0;
        bus.ReadRegister1 = 2'd1; bus.ReadRegister2 = 2'd2;
        #1;
        compared++;
        if (bus.ReadData1 !== 8'hA5) begin
            mismatched++;
            $display("FAIL write_rd1_r1: got %h, expected a5", bus.ReadData1);
        end
        compared++;
        if (bus.ReadData2 !== 8'h3C) begin
            mismatched++;
            $display("FAIL write_rd2_r2: got %h, expected 3c", bus.ReadData2);
        end
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        bus.RegWrite = 1'b1; bus.WriteRegister = 2'd0; bus.WriteData = 8'h11;
        edge_settle();
        @(negedge clk);
        bus.WriteData = 8'h22;
        bus.ReadRegister1 = 2'd0; bus.ReadRegister2 = 2'd0;
        #1;
        compared++;
        if (bus.ReadData1 !== 8'h11) begin
            mismatched++;
            $display("FAIL rdw_before_rd1: got %h, expected 11", bus.ReadData1);
        end
        compared++;
        if (bus.ReadData2 !== 8'h11) begin
            mismatched++;
            $display("FAIL rdw_before_rd2: got %h, expected 11", bus.ReadData2);
        end
        edge_settle();
        compared++;
        if (bus.ReadData1 !== 8'h22) begin
            mismatched++;
            $display("FAIL rdw_after_rd1: got %h, expected 22", bus.ReadData1);
        end
        compared++;
        if (bus.ReadData2 !== 8'h22) begin
            mismatched++;
            $display("FAIL rdw_after_rd2: got %h, expected 22", bus.ReadData2);
        end
        @(negedge clk);
        bus.RegWrite = 1'b0;
    endtask

    task automatic test_write_disabled();
        logic [7:0] exp_mem [4];
        exp_mem = '{8'h22, 8'hA5, 8'h3C, 8'h00};
        @(negedge clk);
        bus.RegWrite = 1'b0; bus.WriteData = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) bus.WriteRegister = 2'(i);
            else       bus.WriteRegister = 'x;
            #1;
            compared++;
            if (bus.wr_onehot !== 4'b0000) begin
                mismatched++;
                $display("FAIL nowrite_onehot[%0d]: got %b, expected 0000", i, bus.wr_onehot);
            end
            edge_settle();
        end
        @(negedge clk);
        bus.WriteRegister = 2'd0;
        for (int i = 0; i < 4; i++) begin
            bus.ReadRegister1 = 2'(i);
            bus.ReadRegister2 = 2'(3 - i);
            #1;
            compared++;
            if (bus.ReadData1 !== exp_mem[i]) begin
                mismatched++;
                $display("FAIL nowrite_rd1[%0d]: got %h, expected %h", i, bus.ReadData1, exp_mem[i]);
            end
            compared++;
            if (bus.ReadData2 !== exp_mem[3-i]) begin
                mismatched++;
                $display("FAIL nowrite_rd2[%0d]: got %h, expected %h", 3 - i, bus.ReadData2, exp_mem[3-i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        reset = 1'b1;
        bus.RegWrite = 1'b1; bus.WriteRegister = 2'd1; bus.WriteData = 8'h77;
        edge_settle();
        @(negedge clk);
        reset = 1'b0;
        bus.RegWrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.ReadRegister1 = 2'(i);
            bus.ReadRegister2 = 2'(i);
            #1;
            compared++;
            if (bus.ReadData1 !== 8'h00) begin
                mismatched++;
                $display("FAIL rstprio_rd1[%0d]: got %h, expected 00", i, bus.ReadData1);
            end
            compared++;
            if (bus.ReadData2 !== 8'h00) begin
                mismatched++;
                $display("FAIL rstprio_rd2[%0d]: got %h, expected 00", i, bus.ReadData2);
            end
        end
    endtask

    task automatic test_top_reg();
        logic [3:0] exp_oh;
        logic [7:0] exp_rd;
`ifdef REGFILE_ZERO_REG_EN
        exp_oh = 4'b0000;
        exp_rd = 8'h00;
`else
        exp_oh = 4'b1000;
        exp_rd = 8'h5A;
`endif
        @(negedge clk);
        bus.RegWrite = 1'b1; bus.WriteRegister = 2'd3; bus.WriteData = 8'h5A;
        #1;
        compared++;
        if (bus.wr_onehot !== exp_oh) begin
            mismatched++;
            $display("FAIL top_onehot: got %b, expected %b", bus.wr_onehot, exp_oh);
        end
        edge_settle();
        @(negedge clk);
        bus.RegWrite = 1'b0;
        bus.ReadRegister1 = 2'd3; bus.ReadRegister2 = 2'd3;
        #1;
        compared++;
        if (bus.ReadData1 !== exp_rd) begin
            mismatched++;
            $display("FAIL top_rd1: got %h, expected %h", bus.ReadData1, exp_rd);
        end
        compared++;
        if (bus.ReadData2 !== exp_rd) begin
            mismatched++;
            $display("FAIL top_rd2: got %h, expected %h", bus.ReadData2, exp_rd);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = 2'd0;
        bus.WriteData     = 8'h00;
        bus.ReadRegister1 = 2'd0;
        bus.ReadRegister2 = 2'd0;

        test_reset();
        test_write();
        test_read_during_write();
        test_write_disabled();
        test_reset_priority();
        test_top_reg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/regfile_decoded.md
Name: regfile_decoded

Overview:
- Synchronous register file that consumes the one-hot write-enable vector produced by the team's enable-cascaded 1-to-2 decoder tree.
- Sits directly downstream of the write-address decoder in the datapath.
- Holds 2**ADDR_W words of WIDTH bits, with one synchronous write port and two combinational read ports.
- Exposes the decoded one-hot write enable so the verifier can check the decode stage and the storage stage together.

Parameters:
ADDR_W, 2, register address width; entry count = 2**ADDR_W
WIDTH, 8, data bits per register
DELAY, 50, gate delay in ps applied to each decode level and each read-mux level

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high; clears all registers
RegWrite  input  1  write request; acts as the enable into the root decoder stage
WriteRegister  input  ADDR_W  destination register index
WriteData  input  WIDTH  data to store
ReadRegister1  input  ADDR_W  read port 1 index
ReadRegister2  input  ADDR_W  read port 2 index
ReadData1  output  WIDTH  contents of register ReadRegister1
ReadData2  output  WIDTH  contents of register ReadRegister2
wr_onehot  output  2**ADDR_W  decoded write enable; bit k = RegWrite & (WriteRegister==k)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Decode:
  - Binary tree of ADDR_W levels of 1-to-2 decoders with enable.
  - The root enable is RegWrite; each level's outputs enable the next level.
  - wr_onehot is at most one-hot and is all zeros when RegWrite=0.
  - Settles within ADDR_W*2*DELAY ps of an input change.
- Storage:
  - Each register k is a WIDTH-bit bank of D flip-flops.
  - Next state: reset ? 0 : (wr_onehot[k] ? WriteData : hold).
- Reset:
  - At the rising edge with reset=1, every register becomes 0, regardless of RegWrite.
  - Reset has priority over a simultaneous write.
  - Reset asserted mid-sequence discards all prior contents at that edge.
  - After reset, ReadData1/2 = 0 for every index.
- Write latency: data is visible on the read ports after the rising edge at which wr_onehot[k]=1, once the read mux settles (at most (ADDR_W+1)*DELAY ps after the edge).
- Read:
  - Purely combinational 2**ADDR_W:1 mux per port, with no clock involvement.
  - Both ports may address the same register, and each returns that register's value.
- Read during write:
  - Reading register k in the same cycle it is written returns the OLD value until the edge, then the new value. There is no bypass.
- Write-enable glitches:
  - RegWrite=0 with any WriteRegister, including X, leaves every register unchanged.
  - WriteRegister may change freely between edges. Only the value settled at the edge matters.
- No undefined indices: every ADDR_W pattern maps to an existing register.
- Bench timing: the bench samples outputs at least 1 ns after any edge or input change. Clock period is at least 10 ns.

Optional Feature:
Macro: REGFILE_ZERO_REG_EN
- Defined:
  - Register index 2**ADDR_W-1 is hardwired to zero.
  - Reads of that index always return 0.
  - Writes to it are dropped, and wr_onehot[2**ADDR_W-1] is forced to 0.
  - Its storage flops may be omitted.
- Undefined: all 2**ADDR_W registers are writable and readable normally.

Test Plan:
1. reset=1 for one edge, then reset=0; read all four indices on both ports -> ReadData1=ReadData2=8'h00 for indices 0..3; wr_onehot=4'b0000 with RegWrite=0.
2. Write 8'hA5 to reg 1 and 8'h3C to reg 2 on consecutive edges. Before each edge, check wr_onehot = 4'b0010 then 4'b0100. Then ReadRegister1=1, ReadRegister2=2 -> 8'hA5, 8'h3C.
3. Same-cycle read/write: reg 0 holds 8'h11; RegWrite=1, WriteRegister=0, WriteData=8'h22, ReadRegister1=0 -> 8'h11 before the edge, 8'h22 after the edge.
4. RegWrite=0, WriteRegister sweeps 0..3, WriteData=8'hFF over four edges -> no register changes; wr_onehot stays 4'b0000.
5. Regs hold 8'hA5/8'h3C; assert reset together with RegWrite=1 to reg 1 with 8'h77 -> after the edge, all reads return 8'h00 (reset wins).
6. Write 8'h5A to reg 3:
   - With REGFILE_ZERO_REG_EN: read reg 3 -> 8'h00 and wr_onehot[3]=0.
   - Without it: read reg 3 -> 8'h5A and wr_onehot=4'b1000 before the edge.
